// File: rtl/rhythm_judge.sv
// Per-lane timing-window judge: grades button presses against note arrivals
// and accumulates score, combo and max combo for the display logic.
module rhythm_judge #(
  parameter int LANES         = 4,
  parameter int CENTER_TICKS  = 50,
  parameter int PERFECT_TICKS = 10,
  parameter int PTS_PERFECT   = 100,
  parameter int PTS_GOOD      = 50,
  parameter int SCORE_W       = 20,
  parameter int COMBO_W       = 10
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Tick,
  input  logic [LANES-1:0]     i_fPush,
  input  logic [LANES-1:0]     i_Note,
  input  logic                 i_Clear,
  output logic [LANES-1:0]     o_JudgeVld,
  output logic [2*LANES-1:0]   o_JudgeCode,
  output logic [SCORE_W-1:0]   o_Score,
  output logic [COMBO_W-1:0]   o_Combo,
  output logic [COMBO_W-1:0]   o_MaxCombo
);

  localparam int MAX_CNT = 2 * CENTER_TICKS;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int SUM_W   = SCORE_W + 1;
  localparam int HIT_W   = COMBO_W + 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(MAX_CNT);

  localparam logic [1:0] C_NONE    = 2'b00;
  localparam logic [1:0] C_PERFECT = 2'b01;
  localparam logic [1:0] C_GOOD    = 2'b10;
  localparam logic [1:0] C_MISS    = 2'b11;

  typedef enum logic {
    IDLE,
    OPEN
  } state_t;

  state_t           st_q  [LANES];
  logic [CNT_W-1:0] cnt_q [LANES];

  logic [LANES-1:0]   vld_d;
  logic [2*LANES-1:0] code_d;
  logic [SUM_W-1:0]   pts_sum;
  logic [SUM_W-1:0]   score_ext;
  logic [HIT_W-1:0]   hit_n;
  logic [HIT_W-1:0]   combo_ext;
  logic               miss_any;
  logic [SCORE_W-1:0] score_d;
  logic [COMBO_W-1:0] combo_d;
  logic [COMBO_W-1:0] max_d;

  function automatic logic [1:0] grade(input logic [CNT_W-1:0] c);
    int e;
    e = int'(c) - CENTER_TICKS;
    if (e < 0) e = -e;
    return (e <= PERFECT_TICKS) ? C_PERFECT : C_GOOD;
  endfunction

  always_comb begin
    vld_d    = '0;
    code_d   = '0;
    pts_sum  = '0;
    hit_n    = '0;
    miss_any = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      logic [1:0] jc;
      jc = C_NONE;
      // press beats expiry and a replacing note; both of those miss
      if (st_q[k] == OPEN) begin
        if (i_fPush[k])
          jc = grade(cnt_q[k]);
        else if (i_Note[k] || (i_Tick && cnt_q[k] == CNT_END))
          jc = C_MISS;
      end
      code_d[2*k +: 2] = jc;
      vld_d[k]         = (jc != C_NONE);
      unique case (1'b1)
        (jc == C_PERFECT): begin
          pts_sum = pts_sum + SUM_W'(PTS_PERFECT);
          hit_n   = hit_n + HIT_W'(1);
        end
        (jc == C_GOOD): begin
          pts_sum = pts_sum + SUM_W'(PTS_GOOD);
          hit_n   = hit_n + HIT_W'(1);
        end
        (jc == C_MISS): miss_any = 1'b1;
        default: ;
      endcase
    end
    score_ext = {1'b0, o_Score} + pts_sum;
    score_d   = score_ext[SCORE_W] ? '1 : score_ext[SCORE_W-1:0];
    combo_ext = {1'b0, o_Combo} + hit_n;
    if (miss_any)
      combo_d = '0;
    else
      combo_d = combo_ext[COMBO_W] ? '1 : combo_ext[COMBO_W-1:0];
    max_d = (combo_d > o_MaxCombo) ? combo_d : o_MaxCombo;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clear) begin
      o_JudgeVld  <= '0;
      o_JudgeCode <= '0;
      o_Score     <= '0;
      o_Combo     <= '0;
      o_MaxCombo  <= '0;
      for (int k = 0; k < LANES; k++) begin
        st_q[k]  <= IDLE;
        cnt_q[k] <= '0;
      end
    end else begin
      o_JudgeVld  <= vld_d;
      o_JudgeCode <= code_d;
      o_Score     <= score_d;
      o_Combo     <= combo_d;
      o_MaxCombo  <= max_d;
      for (int k = 0; k < LANES; k++) begin
        if (i_Note[k]) begin
          st_q[k]  <= OPEN;
          cnt_q[k] <= '0;
        end else if (vld_d[k]) begin
          st_q[k]  <= IDLE;
          cnt_q[k] <= '0;
        end else if (st_q[k] == OPEN && i_Tick) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rhythm_judge.sv
// Scoreboard bench for rhythm_judge: a behavioural model predicts each
// cycle's outputs; scenario tasks add fixed-value checks.
module tb_rhythm_judge;

  logic       clk;
  logic       i_Rst;
  logic       i_Tick;
  logic [3:0] i_fPush;
  logic [3:0] i_Note;
  logic       i_Clear;
  logic [3:0] o_JudgeVld;
  logic [7:0] o_JudgeCode;
  logic [19:0] o_Score;
  logic [9:0] o_Combo;
  logic [9:0] o_MaxCombo;

  int checks   = 0;
  int failures = 0;

  rhythm_judge dut (
    .i_Clk      (clk),
    .i_Rst      (i_Rst),
    .i_Tick     (i_Tick),
    .i_fPush    (i_fPush),
    .i_Note     (i_Note),
    .i_Clear    (i_Clear),
    .o_JudgeVld (o_JudgeVld),
    .o_JudgeCode(o_JudgeCode),
    .o_Score    (o_Score),
    .o_Combo    (o_Combo),
    .o_MaxCombo (o_MaxCombo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  vld;
    logic [7:0]  code;
    logic [19:0] score;
    logic [9:0]  combo;
    logic [9:0]  maxc;
  } exp_t;

  exp_t sbq[$];

  bit m_open [4];
  int m_cnt  [4];
  int m_score, m_combo, m_max;

  // one cycle of stimulus; called at a negedge, returns at the next one
  task automatic step(input logic rst, input logic clr, input logic tick,
                      input logic [3:0] push, input logic [3:0] note);
    exp_t e;
    logic [1:0] jc;
    int pts, hits, err;
    bit miss;
    i_Rst = rst; i_Clear = clr; i_Tick = tick;
    i_fPush = push; i_Note = note;
    e = '0;
    if (rst || clr) begin
      for (int k = 0; k < 4; k++) begin m_open[k] = 0; m_cnt[k] = 0; end
      m_score = 0; m_combo = 0; m_max = 0;
    end else begin
      pts = 0; hits = 0; miss = 0;
      for (int k = 0; k < 4; k++) begin
        jc = 2'b00;
        if (m_open[k]) begin
          if (push[k]) begin
            err = m_cnt[k] > 50 ? m_cnt[k] - 50 : 50 - m_cnt[k];
            jc = (err <= 10) ? 2'b01 : 2'b10;
          end else if (note[k] || (tick && m_cnt[k] == 100)) begin
            jc = 2'b11;
          end
        end
        e.code[2*k +: 2] = jc;
        e.vld[k] = (jc != 2'b00);
        if (jc == 2'b01) begin pts += 100; hits++; end
        if (jc == 2'b10) begin pts += 50; hits++; end
        if (jc == 2'b11) miss = 1;
        if (note[k]) begin m_open[k] = 1; m_cnt[k] = 0; end
        else if (jc != 2'b00) begin m_open[k] = 0; m_cnt[k] = 0; end
        else if (m_open[k] && tick) m_cnt[k]++;
      end
      m_score = m_score + pts;
      if (m_score > 1048575) m_score = 1048575;
      if (miss) m_combo = 0;
      else m_combo = (m_combo + hits > 1023) ? 1023 : m_combo + hits;
      if (m_combo > m_max) m_max = m_combo;
    end
    e.score = m_score[19:0];
    e.combo = m_combo[9:0];
    e.maxc  = m_max[9:0];
    sbq.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks += 5;
      if (o_JudgeVld !== e.vld) begin
        failures++;
        $display("FAIL sb_vld t=%0t got=%b exp=%b", $time, o_JudgeVld, e.vld);
      end
      if (o_JudgeCode !== e.code) begin
        failures++;
        $display("FAIL sb_code t=%0t got=%b exp=%b", $time, o_JudgeCode, e.code);
      end
      if (o_Score !== e.score) begin
        failures++;
        $display("FAIL sb_score t=%0t got=%0d exp=%0d", $time, o_Score, e.score);
      end
      if (o_Combo !== e.combo) begin
        failures++;
        $display("FAIL sb_combo t=%0t got=%0d exp=%0d", $time, o_Combo, e.combo);
      end
      if (o_MaxCombo !== e.maxc) begin
        failures++;
        $display("FAIL sb_max t=%0t got=%0d exp=%0d", $time, o_MaxCombo, e.maxc);
      end
    end
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 4'b0000, 4'b0000);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 4'b0000, 4'b0000);
    step(1, 0, 0, 4'b0000, 4'b0000);
    checks++;
    if ({o_JudgeVld, o_JudgeCode, o_Score, o_Combo, o_MaxCombo} !== '0) begin
      failures++;
      $display("FAIL reset got vld=%b score=%0d combo=%0d exp=0",
               o_JudgeVld, o_Score, o_Combo);
    end
  endtask

  task automatic test_perfect();
    step(0, 0, 0, 4'b0000, 4'b0001);
    ticks(48);
    step(0, 0, 0, 4'b0001, 4'b0000);
    checks++;
    if (o_JudgeVld !== 4'b0001 || o_JudgeCode[1:0] !== 2'b01 ||
        o_Score !== 20'd100 || o_Combo !== 10'd1) begin
      failures++;
      $display("FAIL perfect got vld=%b code=%b score=%0d combo=%0d exp 0001/01/100/1",
               o_JudgeVld, o_JudgeCode, o_Score, o_Combo);
    end
  endtask

  task automatic test_good();
    step(0, 0, 0, 4'b0000, 4'b0010);
    ticks(20);
    step(0, 0, 0, 4'b0010, 4'b0000);
    checks++;
    if (o_JudgeVld !== 4'b0010 || o_JudgeCode[3:2] !== 2'b10 ||
        o_Score !== 20'd150 || o_Combo !== 10'd2) begin
      failures++;
      $display("FAIL good got vld=%b code=%b score=%0d combo=%0d exp 0010/10/150/2",
               o_JudgeVld, o_JudgeCode, o_Score, o_Combo);
    end
  endtask

  task automatic test_miss();
    step(0, 0, 0, 4'b0000, 4'b0100);
    ticks(100);
    checks++;
    if (o_JudgeVld !== 4'b0000) begin
      failures++;
      $display("FAIL miss_early got vld=%b exp=0000", o_JudgeVld);
    end
    ticks(1);
    checks++;
    if (o_JudgeVld !== 4'b0100 || o_JudgeCode[5:4] !== 2'b11 ||
        o_Combo !== 10'd0 || o_MaxCombo !== 10'd2) begin
      failures++;
      $display("FAIL miss got vld=%b code=%b combo=%0d max=%0d exp 0100/11/0/2",
               o_JudgeVld, o_JudgeCode, o_Combo, o_MaxCombo);
    end
  endtask

  task automatic test_dual();
    step(0, 0, 0, 4'b0000, 4'b1001);
    ticks(50);
    step(0, 0, 0, 4'b1001, 4'b0000);
    checks++;
    if (o_JudgeVld !== 4'b1001 || o_JudgeCode !== 8'b01_00_00_01 ||
        o_Score !== 20'd350 || o_Combo !== 10'd2) begin
      failures++;
      $display("FAIL dual got vld=%b code=%b score=%0d combo=%0d exp 1001/01000001/350/2",
               o_JudgeVld, o_JudgeCode, o_Score, o_Combo);
    end
  endtask

  task automatic test_mixed();
    step(0, 0, 0, 4'b0000, 4'b0010);
    ticks(50);
    step(0, 0, 0, 4'b0000, 4'b0001);
    ticks(50);
    step(0, 0, 1, 4'b0001, 4'b0000);
    checks++;
    if (o_JudgeVld !== 4'b0011 || o_JudgeCode[3:0] !== 4'b1101 ||
        o_Score !== 20'd450 || o_Combo !== 10'd0) begin
      failures++;
      $display("FAIL mixed got vld=%b code=%b score=%0d combo=%0d exp 0011/1101/450/0",
               o_JudgeVld, o_JudgeCode, o_Score, o_Combo);
    end
    step(0, 0, 0, 4'b0000, 4'b1000);
    ticks(5);
    step(0, 0, 0, 4'b0000, 4'b1000);
    checks++;
    if (o_JudgeVld !== 4'b1000 || o_JudgeCode[7:6] !== 2'b11) begin
      failures++;
      $display("FAIL renote got vld=%b code=%b exp 1000/11", o_JudgeVld, o_JudgeCode);
    end
    ticks(10);
    step(0, 0, 0, 4'b1000, 4'b0000);
    checks++;
    if (o_JudgeCode[7:6] !== 2'b10 || o_Score !== 20'd500 || o_Combo !== 10'd1) begin
      failures++;
      $display("FAIL restart got code=%b score=%0d combo=%0d exp 10/500/1",
               o_JudgeCode[7:6], o_Score, o_Combo);
    end
  endtask

  task automatic test_back_to_back();
    step(0, 0, 0, 4'b0000, 4'b1111);
    for (int i = 0; i < 256; i++) step(0, 0, 0, 4'b1111, 4'b1111);
    checks++;
    if (o_Combo !== 10'd1023 || o_MaxCombo !== 10'd1023) begin
      failures++;
      $display("FAIL combo_sat got combo=%0d max=%0d exp 1023/1023", o_Combo, o_MaxCombo);
    end
    ticks(50);
    step(0, 0, 0, 4'b0001, 4'b0000);
    checks++;
    if (o_JudgeCode[1:0] !== 2'b01 || o_Combo !== 10'd1023) begin
      failures++;
      $display("FAIL combo_hold got code=%b combo=%0d exp 01/1023",
               o_JudgeCode[1:0], o_Combo);
    end
    step(0, 0, 0, 4'b0000, 4'b0001);
    ticks(30);
    step(1, 0, 1, 4'b0000, 4'b0000);
    checks++;
    if ({o_JudgeVld, o_JudgeCode, o_Score, o_Combo, o_MaxCombo} !== '0) begin
      failures++;
      $display("FAIL mid_reset got vld=%b score=%0d combo=%0d max=%0d exp 0",
               o_JudgeVld, o_Score, o_Combo, o_MaxCombo);
    end
    for (int i = 0; i < 120; i++) begin
      step(0, 0, 1, 4'b0000, 4'b0000);
      checks++;
      if (o_JudgeVld !== 4'b0000) begin
        failures++;
        $display("FAIL post_reset_vld got=%b exp=0000", o_JudgeVld);
      end
    end
  endtask

  task automatic test_clear();
    step(0, 0, 0, 4'b0000, 4'b0100);
    step(0, 0, 0, 4'b0010, 4'b0000);
    checks++;
    if (o_JudgeVld !== 4'b0000) begin
      failures++;
      $display("FAIL idle_press got vld=%b exp=0000", o_JudgeVld);
    end
    step(0, 0, 0, 4'b0100, 4'b0001);
    checks++;
    if (o_Score !== 20'd50) begin
      failures++;
      $display("FAIL pre_clear got score=%0d exp=50", o_Score);
    end
    ticks(50);
    step(0, 1, 1, 4'b0001, 4'b0000);
    checks++;
    if (o_JudgeVld !== 4'b0000 || o_Score !== 20'd0 || o_Combo !== 10'd0) begin
      failures++;
      $display("FAIL clear got vld=%b score=%0d combo=%0d exp 0/0/0",
               o_JudgeVld, o_Score, o_Combo);
    end
    step(0, 0, 0, 4'b0001, 4'b0001);
    checks++;
    if (o_JudgeVld !== 4'b0000) begin
      failures++;
      $display("FAIL note_press_idle got vld=%b exp=0000", o_JudgeVld);
    end
    step(0, 0, 0, 4'b0001, 4'b0000);
    checks++;
    if (o_JudgeVld !== 4'b0001 || o_JudgeCode[1:0] !== 2'b10 || o_Score !== 20'd50) begin
      failures++;
      $display("FAIL after_clear got vld=%b code=%b score=%0d exp 0001/10/50",
               o_JudgeVld, o_JudgeCode[1:0], o_Score);
    end
  endtask

  initial begin
    i_Rst = 1'b1; i_Clear = 1'b0; i_Tick = 1'b0;
    i_fPush = '0; i_Note = '0;
    @(negedge clk);
    test_reset();
    test_perfect();
    test_good();
    test_miss();
    test_dual();
    test_mixed();
    test_back_to_back();
    test_clear();
    step(0, 0, 0, 4'b0000, 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
